// File: rtl/port_ingress_buffer.sv
// Per-port ingress stage: validates incoming packets, buffers legal ones in a
// circular FIFO and presents the head entry to the switch core. Saturating
// accept/drop counters are kept for debug and scoreboarding.
module port_ingress_buffer #(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned PORT_ID        = 0,
  parameter int unsigned ALLOW_LOOPBACK = 0,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_PORTS-1:0]       in_source,
  input  logic [NUM_PORTS-1:0]       in_target,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_PORTS-1:0]       out_source,
  output logic [NUM_PORTS-1:0]       out_target,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           accept_cnt,
  output logic [CNT_W-1:0]           drop_cnt,
  input  logic                       cnt_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = 2 * NUM_PORTS + DATA_W;
  localparam logic [NUM_PORTS-1:0] OWN_SRC  = {{(NUM_PORTS-1){1'b0}}, 1'b1} << PORT_ID;
  localparam logic [LW-1:0]        FULL_LVL = LW'(DEPTH);
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    lvl;
  logic             legal;
  logic             xfer;
  logic             wr_en;
  logic             drop_en;
  logic             pop;
  logic [EW-1:0]    head;

  // Handshake flags derive from registered occupancy only.
  always_comb begin
    in_ready  = (lvl != FULL_LVL);
    out_valid = (lvl != '0);
    level     = lvl;
  end

  // Packet legality, transfer qualification and head presentation.
  always_comb begin
    legal   = (in_source == OWN_SRC) && (in_target != '0) &&
              ((ALLOW_LOOPBACK != 0) || !in_target[PORT_ID]);
    xfer    = in_valid && in_ready;
    wr_en   = xfer && legal;
    drop_en = xfer && !legal;
    pop     = out_valid && out_ready;
    head    = mem[rd_ptr];
    // Storage is not reset; gating on out_valid gives zero fields after reset.
    {out_source, out_target, out_data} = out_valid ? head : '0;
  end

  // Payload storage, written at the tail on a legal transfer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {in_source, in_target, in_data};
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   lvl <= lvl + LW'(1);
        2'b01:   lvl <= lvl - LW'(1);
        default: lvl <= lvl;
      endcase
    end
  end

  // Saturating accept/drop counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_cnt <= '0;
      drop_cnt   <= '0;
    end else if (cnt_clr) begin
      accept_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (wr_en && (accept_cnt != CNT_MAX))  accept_cnt <= accept_cnt + CNT_W'(1);
      if (drop_en && (drop_cnt != CNT_MAX))  drop_cnt   <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/port_ingress_buffer.md
# port_ingress_buffer

Parametrised per-port ingress stage for the N-port switch, sitting between a port's input pins and the switch core. Accepts packets (source, target, data) over a valid/ready handshake, drops illegal packets, buffers legal ones in a DEPTH-entry FIFO, and presents them to the core over a second valid/ready handshake. Keeps saturating accept and drop counters for scoreboarding and debug.

## Interface
- NUM_PORTS, 4: switch port count; also the width of the source and target fields.
- DATA_W, 8: payload width.
- DEPTH, 8: FIFO entries; must be a power of two and at least 2.
- PORT_ID, 0: index of this port, 0..NUM_PORTS-1.
- ALLOW_LOOPBACK, 0: when 0, a packet targeting its own port is illegal.
- CNT_W, 16: counter width.
- clk  in  1  switch clock.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- in_valid  in  1  packet offered.
- in_ready  out  1  block can take a packet this cycle.
- in_source  in  NUM_PORTS  one-hot source port.
- in_target  in  NUM_PORTS  target bitmask; more than one bit set means multicast.
- in_data  in  DATA_W  payload.
- out_valid  out  1  head packet available.
- out_ready  in  1  core consumes the head packet.
- out_source, out_target, out_data  out  NUM_PORTS/NUM_PORTS/DATA_W  head packet fields.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- accept_cnt  out  CNT_W  legal packets written.
- drop_cnt  out  CNT_W  illegal packets consumed and discarded.
- cnt_clr  in  1  synchronous clear of both counters.

## Operation
- Input handshake: a packet transfers when in_valid && in_ready on a rising edge. in_ready = (level != DEPTH). It is a function of registered state only and never depends on in_valid or in_*.
- A transferred packet is legal only when all of these hold:
  - in_source == 1<<PORT_ID;
  - in_target != 0;
  - ALLOW_LOOPBACK is 1, or in_target[PORT_ID] == 0.
- A legal packet is written at the tail and accept_cnt increments.
- An illegal packet is discarded: FIFO unchanged, drop_cnt increments. It still needs in_ready to be high.
- Output handshake: out_valid = (level != 0). The out_* fields always show the head entry. The head pops when out_valid && out_ready.
- While out_valid && !out_ready, out_* hold stable.
- out_* are don't-care while out_valid is 0. The bench must not check them then.
- FIFO: circular buffer with read and write pointers of $clog2(DEPTH) bits. Pointers wrap from DEPTH-1 to 0.
- level tracking per cycle: +1 on legal write only, -1 on pop only, unchanged on both or neither.
- Simultaneous legal write and pop at a level between 1 and DEPTH-1: level unchanged, FIFO order preserved.
- Full: in_ready is 0, so no input transfer happens. A pop in that cycle drops level to DEPTH-1, and in_ready rises the next cycle. There is no same-cycle bypass.
- Empty: a write sets out_valid the next cycle. There is no fall-through.
- Counters saturate at 2^CNT_W-1.
- cnt_clr forces both counters to 0 and has priority over an increment in the same cycle. The FIFO is unaffected.
- Reset mid-operation: pointers, level and counters return to 0 immediately. Buffered packets are lost and out_valid falls asynchronously.

## Timing
- Reset values: in_ready=1 (DEPTH>0), out_valid=0, level=0, accept_cnt=0, drop_cnt=0. out_source, out_target and out_data reset to 0.
- Latency: a packet accepted at edge N into an empty FIFO has out_valid=1 after edge N.
- Throughput: one packet per cycle sustained when out_ready is held at 1.
- level, accept_cnt and drop_cnt update on the same edge as the causing transfer.
- Drivers apply input changes with non-blocking assignment after the clock edge. Monitors sample out_* on the edge where out_valid && out_ready.

## Test plan
- Reset, then one legal packet at PORT_ID=0: source=4'b0001, target=4'b0100, data=8'hA5 -> out_valid=1 the following cycle with the same fields; accept_cnt=1; level returns to 0 after the pop.
- Illegal packets with source=4'b0010, then target=4'b0000, then target=4'b0001 (ALLOW_LOOPBACK=0) -> no out_valid; drop_cnt=3; accept_cnt=0; in_ready stays 1.
- out_ready=0, offer 10 legal packets with data 0..9 -> in_ready falls after 8 transfers; level=8. Then out_ready=1 -> data 0..7 emerge in order, then 8 and 9. There is no pop/push in the same full cycle.
- out_ready toggled 1-0-1-0 with in_valid held high for 20 packets -> no loss and no duplication, order preserved, out_* stable during stalls, and pointer wrap exercised at least twice.
- CNT_W=4: offer 20 legal packets -> accept_cnt saturates at 15. Then assert cnt_clr in the same cycle as a transfer -> accept_cnt=0.
- Assert rst_n=0 with 5 packets buffered -> out_valid=0 and level=0 with no clock edge. After release, a new packet with data=8'h3C is the first one out.
